// File: rtl/io_port.sv
// io_port -- peripheral end of the CU's I/O transfer.
// A CU write to DATA pushes the bus word into a TX FIFO, which drains over a
// valid/ready stream to an external sink. Words from an external RX stream
// fill an RX FIFO, which the CU pops by reading DATA. STATUS and CTRL
// registers sit next to DATA. Unused address 3 reads as 0.
//
// Ports:
//   clk, rst          system clock; synchronous reset, active low
//   addr              I/O address (only [1:0] decoded)
//   bus_in / bus_out  shared data bus in; read data out (0 when not reading)
//   io_oe / io_we     CU read / write strobes, one access per high cycle
//   tx_data/valid/ready   outbound stream (TX FIFO head)
//   rx_data/valid/ready   inbound stream (into RX FIFO)

module io_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [PW:0]  count,
  output logic         empty,
  output logic         full
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset; only pointers and counts define the state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module io_port #(
  parameter int word_width = 16,
  parameter int fifo_depth = 4,
  parameter int ptr_width  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] addr,
  input  logic [word_width-1:0] bus_in,
  output logic [word_width-1:0] bus_out,
  input  logic                  io_oe,
  input  logic                  io_we,
  output logic [word_width-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [word_width-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);
  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2;

  logic [1:0]           sel;
  logic                 wr_en, rd_en;
  logic                 data_wr, ctrl_wr, data_rd, flush;
  logic                 tx_full, tx_empty, tx_pop;
  logic                 rx_full, rx_empty, rx_pop, rx_push;
  logic [ptr_width:0]   tx_count, rx_count;
  logic [word_width-1:0] rx_head, status;
  logic                 tx_ovf;
  logic                 unused_addr;

  assign unused_addr = &{1'b0, addr[word_width-1:2]};

  assign sel     = addr[1:0];
  assign wr_en   = rst & io_we;
  // A simultaneous write wins; the read is dropped and bus_out stays 0.
  assign rd_en   = rst & io_oe & ~io_we;
  assign data_wr = wr_en & (sel == A_DATA);
  assign ctrl_wr = wr_en & (sel == A_CTRL);
  assign data_rd = rd_en & (sel == A_DATA);
  assign flush   = ctrl_wr & bus_in[1];

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = rst & ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = data_rd & ~rx_empty;

  io_fifo #(.W(word_width), .DEPTH(fifo_depth), .PW(ptr_width)) u_tx (
    .clk(clk), .rst(rst), .flush(flush), .push(data_wr), .pop(tx_pop),
    .wdata(bus_in), .rdata(tx_data), .count(tx_count),
    .empty(tx_empty), .full(tx_full)
  );

  io_fifo #(.W(word_width), .DEPTH(fifo_depth), .PW(ptr_width)) u_rx (
    .clk(clk), .rst(rst), .flush(flush), .push(rx_push), .pop(rx_pop),
    .wdata(rx_data), .rdata(rx_head), .count(rx_count),
    .empty(rx_empty), .full(rx_full)
  );

  // Sticky overflow: set when a DATA write meets a full TX FIFO with no
  // same-edge drain. Flush leaves it alone; only CTRL bit0 clears it.
  always_ff @(posedge clk) begin
    if (!rst)                         tx_ovf <= 1'b0;
    else if (ctrl_wr && bus_in[0])    tx_ovf <= 1'b0;
    else if (data_wr && tx_full && !tx_pop) tx_ovf <= 1'b1;
  end

  always_comb begin
    status      = '0;
    status[0]   = ~rx_empty;
    status[1]   = tx_full;
    status[2]   = tx_empty;
    status[3]   = tx_ovf;
    status[7:4] = 4'(rx_count);
  end

  always_comb begin
    bus_out = '0;
    if (rd_en) begin
      case (sel)
        A_DATA:  bus_out = rx_empty ? '0 : rx_head;
        A_STAT:  bus_out = status;
        default: bus_out = '0;
      endcase
    end
  end

  logic unused_tx_count;
  assign unused_tx_count = &{1'b0, tx_count};
endmodule
